// File: rtl/cpld_uart_slave_pkg.sv
// Shared types and register map for the CPLD UART Wishbone slave.
// Port-side FSM states, register offsets and STATUS bit positions.
package cpld_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RD,
    RD_REC,
    WR_SU,
    WR,
    WR_HLD,
    TX_WAIT
  } port_state_t;

  localparam logic [31:0] REG_DATA   = 32'h0;
  localparam logic [31:0] REG_STATUS = 32'h4;

  localparam int ST_RX_AVAIL = 0;
  localparam int ST_TX_IDLE  = 1;
  localparam int ST_RX_FULL  = 2;

  function automatic logic [31:0] status_word(
    input logic rx_avail,
    input logic tx_idle,
    input logic rx_full
  );
    logic [31:0] w;
    w = '0;
    w[ST_RX_AVAIL] = rx_avail;
    w[ST_TX_IDLE]  = tx_idle;
    w[ST_RX_FULL]  = rx_full;
    return w;
  endfunction

endpackage

// File: rtl/cpld_uart_slave_if.sv
// Wishbone classic-pipelined bus bundle for the CPLD UART slave.
// Master drives request fields; slave returns data and handshake.
interface cpld_uart_slave_if;

  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic [31:0] adr_i;
  logic [3:0]  sel_i;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic        ack_o;
  logic        stall_o;
  logic        err_o;
  logic        rty_o;

  modport master (
    output dat_i, adr_i, sel_i,
    output cyc_i, stb_i, we_i,
    input  dat_o, ack_o, stall_o,
    input  err_o, rty_o
  );

  modport slave (
    input  dat_i, adr_i, sel_i,
    input  cyc_i, stb_i, we_i,
    output dat_o, ack_o, stall_o,
    output err_o, rty_o
  );

endinterface

// File: rtl/cpld_uart_slave_rx_fifo.sv
// Receive byte FIFO: synchronous push/pop, full/empty flags.
// Push and pop in one cycle both take effect; count is unchanged.
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/cpld_uart_slave.sv
// Wishbone slave bridging the system bus to the CPLD UART.
// Shares the BaseRAM low byte via a request/grant pad mux.
module cpld_uart_slave
  import cpld_uart_pkg::*;
#(
  parameter int RX_DEPTH = 4,
  parameter int RD_PULSE = 2,
  parameter int WR_PULSE = 2
) (
  input  logic       clk_bus,
  input  logic       rst_bus,
  cpld_uart_slave_if.slave wb,
  output logic       bus_req,
  input  logic       bus_gnt,
  input  logic [7:0] uart_dat_i,
  output logic [7:0] uart_dat_o,
  output logic       uart_dat_oe,
  output logic       uart_rdn,
  output logic       uart_wrn,
  input  logic       uart_dataready,
  input  logic       uart_tbre,
  input  logic       uart_tsre,
  output logic       irq,
  input  logic       irq_permitted
);

  localparam logic [7:0] RD_LAST = 8'(RD_PULSE - 1);
  localparam logic [7:0] WR_LAST = 8'(WR_PULSE - 1);

  port_state_t state;
  logic [7:0]  pcnt;
  logic        dir_wr;
  logic        ack_q;
  logic [31:0] dat_q;
  logic [7:0]  tx_hold;
  logic        tx_full;
  logic        tsre_seen;

  logic        is_status;
  logic        wr_data_req;
  logic        accept;
  logic        tx_load;
  logic        rx_push;
  logic        rx_pop;
  logic [7:0]  rx_head;
  logic        rx_empty;
  logic        rx_full;
  logic [31:0] status;
  logic        unused_ok;

  assign is_status   = (wb.adr_i[2] == REG_STATUS[2]);
  assign wr_data_req = wb.cyc_i & wb.stb_i & wb.we_i & ~is_status;
  assign wb.stall_o  = ack_q | (wr_data_req & tx_full);
  assign accept      = wb.cyc_i & wb.stb_i & ~wb.stall_o;
  assign tx_load     = accept & wb.we_i & ~is_status;
  assign rx_pop      = accept & ~wb.we_i & ~is_status;
  assign rx_push     = (state == RD) && (pcnt == RD_LAST);

  assign status = status_word(~rx_empty,
                              ~tx_full & tsre_seen,
                              rx_full);

  assign wb.ack_o = ack_q;
  assign wb.dat_o = dat_q;
  assign wb.err_o = 1'b0;
  assign wb.rty_o = 1'b0;

  assign unused_ok = ^{wb.sel_i, wb.adr_i[31:3],
                       wb.adr_i[1:0], wb.dat_i[31:8],
                       uart_tbre};

  uart_rx_fifo #(
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk_bus),
    .rst   (rst_bus),
    .push  (rx_push),
    .din   (uart_dat_i),
    .pop   (rx_pop),
    .dout  (rx_head),
    .empty (rx_empty),
    .full  (rx_full)
  );

  always_ff @(posedge clk_bus) begin
    if (rst_bus) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      tx_hold <= '0;
    end else begin
      ack_q <= accept;
      if (accept && !wb.we_i) begin
        if (is_status)     dat_q <= status;
        else if (rx_empty) dat_q <= '0;
        else               dat_q <= {24'h0, rx_head};
      end
      if (tx_load) tx_hold <= wb.dat_i[7:0];
    end
  end

  // RX has priority; a byte is only fetched while the FIFO has room
  always_ff @(posedge clk_bus) begin
    if (rst_bus) begin
      state       <= IDLE;
      pcnt        <= '0;
      dir_wr      <= 1'b0;
      bus_req     <= 1'b0;
      uart_rdn    <= 1'b1;
      uart_wrn    <= 1'b1;
      uart_dat_oe <= 1'b0;
      uart_dat_o  <= '0;
      tx_full     <= 1'b0;
      tsre_seen   <= 1'b1;
      irq         <= 1'b0;
    end else begin
      irq <= irq_permitted & ~rx_empty;
      if (tx_load) tx_full <= 1'b1;
      unique case (state)
        IDLE: begin
          if (uart_dataready && !rx_full) begin
            dir_wr  <= 1'b0;
            bus_req <= 1'b1;
            state   <= REQ;
          end else if (tx_full) begin
            dir_wr  <= 1'b1;
            bus_req <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (bus_gnt) begin
            pcnt <= '0;
            if (dir_wr) begin
              uart_dat_oe <= 1'b1;
              uart_dat_o  <= tx_hold;
              state       <= WR_SU;
            end else begin
              uart_rdn <= 1'b0;
              state    <= RD;
            end
          end
        end
        RD: begin
          if (pcnt == RD_LAST) begin
            uart_rdn <= 1'b1;
            state    <= RD_REC;
          end else begin
            pcnt <= pcnt + 8'd1;
          end
        end
        RD_REC: begin
          bus_req <= 1'b0;
          state   <= IDLE;
        end
        WR_SU: begin
          uart_wrn <= 1'b0;
          state    <= WR;
        end
        WR: begin
          // holding frees here so a queued write lands during hold
          if (pcnt == WR_LAST) begin
            uart_wrn  <= 1'b1;
            tx_full   <= 1'b0;
            tsre_seen <= 1'b0;
            state     <= WR_HLD;
          end else begin
            pcnt <= pcnt + 8'd1;
          end
        end
        WR_HLD: begin
          uart_dat_oe <= 1'b0;
          bus_req     <= 1'b0;
          state       <= TX_WAIT;
        end
        TX_WAIT: begin
          if (uart_tsre) begin
            tsre_seen <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cpld_uart_slave.md
# cpld_uart_slave

Wishbone slave that connects the SystemOnCat system bus to the board's CPLD UART controller. The CPLD data lines share the low byte of the BaseRAM data bus, so the block asks the top-level pad mux for that byte before every strobe. It generates the `uart_rdn`/`uart_wrn` pulse sequences and buffers received bytes in a small FIFO. It raises a PLIC interrupt while receive data is pending.

## Interface
Parameters:
- `RX_DEPTH`, 4: receive FIFO entries (power of two, ≥2).
- `RD_PULSE`, 2: `clk_bus` cycles `uart_rdn` is held low.
- `WR_PULSE`, 2: `clk_bus` cycles `uart_wrn` is held low.

Ports:
- `clk_bus`  in  1  bus clock, single clock domain.
- `rst_bus`  in  1  reset, synchronous, active-high.
- `dat_i`  in  32  Wishbone write data (only [7:0] used).
- `dat_o`  out  32  Wishbone read data.
- `adr_i`  in  32  byte address; only `adr_i[2]` decoded.
- `sel_i`  in  4  byte select; ignored.
- `cyc_i`, `stb_i`, `we_i`  in  1  Wishbone cycle, strobe, write enable.
- `ack_o`, `stall_o`, `err_o`, `rty_o`  out  1  Wishbone acknowledge, stall, error, retry; `err_o` and `rty_o` are tied to 0.
- `bus_req`  out  1  request for the shared low data byte.
- `bus_gnt`  in  1  top-level mux grants the low byte; RAM is deselected while granted.
- `uart_dat_i`  in  8  byte sampled from the shared bus.
- `uart_dat_o`  out  8  byte to drive onto the shared bus.
- `uart_dat_oe`  out  1  drive enable for `uart_dat_o`.
- `uart_rdn`, `uart_wrn`  out  1  CPLD read/write strobes, low active.
- `uart_dataready`, `uart_tbre`, `uart_tsre`  in  1  CPLD status inputs.
- `irq`  out  1  interrupt to the PLIC.
- `irq_permitted`  in  1  interrupt enable from the PLIC.

## Operation
Registers:
- DATA (`adr_i[2]`=0), read: pops the FIFO head into `dat_o[7:0]`; returns 0 if the FIFO is empty.
- DATA, write: loads `dat_i[7:0]` into a one-byte TX holding register.
- STATUS (`adr_i[2]`=1), read-only: bit0 = FIFO non-empty, bit1 = TX holding empty and `tsre_seen`, bit2 = FIFO full. All other bits are 0. Writes to STATUS are acked and ignored.

Port-side FSM (states IDLE, REQ, RD, RD_REC, WR_SU, WR, WR_HLD, TX_WAIT):
- IDLE: if `uart_dataready` and the FIFO is not full, go to REQ(read). Otherwise, if TX holding is full, go to REQ(write). RX wins when both are pending.
- REQ: `bus_req`=1; wait for `bus_gnt`.
  - On grant (read): RD.
  - On grant (write): WR_SU.
- RD: `uart_rdn`=0 for RD_PULSE cycles. Sample `uart_dat_i` into the FIFO on the last cycle. Go to RD_REC.
- RD_REC: `uart_rdn`=1; one recovery cycle, then IDLE.
- WR_SU: `uart_dat_oe`=1 for one setup cycle. Go to WR.
- WR: `uart_wrn`=0 for WR_PULSE cycles. Go to WR_HLD.
- WR_HLD: `uart_wrn`=1 with `uart_dat_oe` still 1 for one cycle. Clear TX holding and `tsre_seen`. Go to TX_WAIT.
- TX_WAIT: drop `bus_req`. Stay until `uart_tsre`=1, then set `tsre_seen` and go to IDLE.
- `bus_req` stays at 1 from REQ through WR_HLD/RD_REC. It drops on the exit from RD_REC/WR_HLD.
- `irq` = `irq_permitted` & FIFO non-empty, registered.

## Timing
- Request acceptance: a request is accepted on any cycle with `cyc_i & stb_i & !stall_o`.
- `ack_o` is high for exactly one cycle, in the cycle after acceptance. `dat_o` is valid during that cycle. There is no pipelining: `stall_o`=1 while an ack is pending.
- `stall_o` is also 1 when a DATA write is presented while TX holding is full. The write is accepted once holding clears.
- Simultaneous pop and FIFO push in the same cycle: both happen and the count is unchanged.
- Pop from an empty FIFO: no pointer change.
- The FIFO never overflows: RD is not entered while the FIFO is full.
- Pointers wrap modulo RX_DEPTH.
- `tsre_seen` resets to 1.
- Reset values: `ack_o`=0, `stall_o`=0, `dat_o`=0, `bus_req`=0, `uart_dat_oe`=0, `uart_rdn`=1, `uart_wrn`=1, `irq`=0, FSM=IDLE, FIFO empty, TX holding empty.
- Reset mid-strobe: the strobes return high on the first reset edge. Any partial byte is discarded.
- `bus_gnt` deasserting mid-transfer is a protocol violation by the mux and is not handled.

## Structure
- Package `cpld_uart_pkg` holds:
  - the FSM state enum;
  - the register offsets DATA=0 and STATUS=4;
  - the STATUS bit positions.
- Sub-module `uart_rx_fifo`, parameterised by depth: synchronous push/pop with full/empty flags and simultaneous push+pop. Everything else lives in one file.

## Test plan
- Read path: `uart_dataready`=1 with `uart_dat_i`=0x41 and `bus_gnt` granted 3 cycles after `bus_req`.
  - `uart_rdn` is low for 2 cycles.
  - A STATUS read returns 0x3.
  - A DATA read returns 0x41.
  - A second DATA read returns 0.
- Write path: write 0x5A to DATA.
  - `uart_dat_o`=0x5A with `uart_dat_oe` high one cycle before `uart_wrn` falls.
  - `uart_wrn` is low for 2 cycles.
  - STATUS bit1=0 until `uart_tsre` rises.
- Back-pressure: two DATA writes back-to-back with `uart_tsre` held at 0. The second write stalls until the first reaches WR_HLD; the second byte is then sent only after `uart_tsre`=1.
- FIFO full: keep `dataready`=1 with bytes 1..5. After 4 bytes, STATUS bit2=1 and no further `uart_rdn` pulse. Four pops return 1,2,3,4, after which the fifth byte is fetched.
- Interrupt: with `irq_permitted`=1 and one byte received, `irq`=1. After the pop, `irq`=0. With `irq_permitted`=0, `irq` stays 0.
- Reset during RD: assert `rst_bus` in the second low cycle of `uart_rdn`. On the next edge `uart_rdn`=1, `bus_req`=0 and the FIFO is empty.
